// File: rtl/oracle_evt_pkg.sv
// ----------------------------------------------------------------------------
// oracle_evt_pkg
//   Shared types for the oracle event scheduler.
//   evt_kind_e : pipeline stage that produced the event
//   evt_t      : packed event record {kind, id, pc, data}
//   EVT_W      : width of evt_t, used for flattened event buses
// ----------------------------------------------------------------------------
package oracle_evt_pkg;

    typedef enum logic [2:0] {
        DECODE    = 3'd0,
        RENAME    = 3'd1,
        ISSUE     = 3'd2,
        WRITEBACK = 3'd3,
        COMMIT    = 3'd4,
        SQUASH    = 3'd5
    } evt_kind_e;

    typedef struct packed {
        evt_kind_e   kind;
        logic [31:0] id;
        logic [63:0] pc;
        logic [63:0] data;
    } evt_t;

    localparam int unsigned EVT_W = $bits(evt_t);

endpackage

// File: rtl/oracle_evt_fifo.sv
// ----------------------------------------------------------------------------
// oracle_evt_fifo
//   Per-port FIFO of DEPTH entries, each {timestamp, event}. Pointers carry
//   one extra wrap bit so full and empty are distinguishable without a count.
//   Ports:
//     clk_i, rst_ni          clock, asynchronous active-low reset
//     push_i, ts_i, evt_i    write request with its arrival timestamp
//     pop_i                  discard the head entry
//     full_o, empty_o        occupancy flags
//     head_ts_o, head_evt_o  oldest entry (valid when !empty_o)
// ----------------------------------------------------------------------------
module oracle_evt_fifo
    import oracle_evt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [TS_W-1:0]  ts_i,
    input  logic [EVT_W-1:0] evt_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [TS_W-1:0]  head_ts_o,
    output logic [EVT_W-1:0] head_evt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [TS_W-1:0]  ts_mem  [DEPTH];
    logic [EVT_W-1:0] evt_mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Guarded locally as well so the FIFO is safe regardless of the caller.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i  & ~empty_o;

    assign head_ts_o  = ts_mem[rd_ptr[AW-1:0]];
    assign head_evt_o = evt_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only observed between the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            ts_mem[wr_ptr[AW-1:0]]  <= ts_i;
            evt_mem[wr_ptr[AW-1:0]] <= evt_i;
        end
    end

endmodule

// File: rtl/oracle_evt_sched.sv
// ----------------------------------------------------------------------------
// oracle_evt_sched
//   Merges NPORT event streams into one, oldest-first by arrival timestamp.
//   Each port has its own FIFO; the head with the oldest timestamp (lowest
//   port index on a tie) is presented on the output.
//   Ports:
//     clk_i, rst_ni   clock, asynchronous active-low reset
//     in_valid_i      per-port event valid
//     in_ready_o      per-port accept (FIFO not full)
//     in_evt_i        per-port event records, port p at [p*EVT_W +: EVT_W]
//     out_valid_o     an event is pending
//     out_ready_i     consumer accepts out_evt_o
//     out_evt_o       selected event
//     out_port_o      source port of out_evt_o
//     evt_cnt_o       events delivered since reset (wraps)
//     age_err_o       sticky: a pending event got too old to order safely
// ----------------------------------------------------------------------------
module oracle_evt_sched
    import oracle_evt_pkg::*;
#(
    parameter int unsigned NPORT = 4,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TS_W  = 16,
    localparam int unsigned PORT_W = $clog2(NPORT)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NPORT-1:0]       in_valid_i,
    output logic [NPORT-1:0]       in_ready_o,
    input  logic [NPORT*EVT_W-1:0] in_evt_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [EVT_W-1:0]       out_evt_o,
    output logic [PORT_W-1:0]      out_port_o,
    output logic [31:0]            evt_cnt_o,
    output logic                   age_err_o
);

    // Beyond this age the signed timestamp difference can no longer order
    // events correctly.
    localparam logic [TS_W-1:0] AGE_LIM = {1'b0, {(TS_W-1){1'b1}}};

    logic [TS_W-1:0]  ts_q;
    logic [NPORT-1:0] full;
    logic [NPORT-1:0] empty;
    logic [NPORT-1:0] push;
    logic [NPORT-1:0] pop;
    logic [TS_W-1:0]  head_ts  [NPORT];
    logic [EVT_W-1:0] head_evt [NPORT];

    logic              sel_found;
    logic [PORT_W-1:0] sel_idx;
    logic [TS_W-1:0]   sel_ts;
    logic [TS_W-1:0]   sel_age;
    logic              out_fire;

    // a strictly older than b, using modular distance so ts wrap is harmless
    function automatic logic ts_before(input logic [TS_W-1:0] a,
                                       input logic [TS_W-1:0] b);
        logic [TS_W-1:0] d;
        d = a - b;
        return d[TS_W-1];
    endfunction

    assign in_ready_o = ~full;
    assign push       = in_valid_i & ~full;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        oracle_evt_fifo #(
            .DEPTH (DEPTH),
            .TS_W  (TS_W)
        ) u_fifo (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .push_i     (push[p]),
            .pop_i      (pop[p]),
            .ts_i       (ts_q),
            .evt_i      (in_evt_i[p*EVT_W +: EVT_W]),
            .full_o     (full[p]),
            .empty_o    (empty[p]),
            .head_ts_o  (head_ts[p]),
            .head_evt_o (head_evt[p])
        );

        assign pop[p] = out_fire && (sel_idx == PORT_W'(p));
    end

    // Scan in ascending port order and replace only on strictly older, which
    // makes ties resolve to the lowest index.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_ts    = '0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (!empty[p] && (!sel_found || ts_before(head_ts[p], sel_ts))) begin
                sel_found = 1'b1;
                sel_idx   = p[PORT_W-1:0];
                sel_ts    = head_ts[p];
            end
        end
    end

    assign out_valid_o = sel_found;
    assign out_evt_o   = head_evt[sel_idx];
    assign out_port_o  = sel_idx;
    assign out_fire    = out_valid_o & out_ready_i;
    assign sel_age     = ts_q - sel_ts;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ts_q      <= '0;
            evt_cnt_o <= '0;
            age_err_o <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (out_fire)
                evt_cnt_o <= evt_cnt_o + 32'd1;
            if (out_valid_o && (sel_age >= AGE_LIM))
                age_err_o <= 1'b1;
        end
    end

endmodule
